// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word channel from the SPI/wishbone bridge into the ccff loader.
// A word transfers on every prog_clk edge where cfg_valid && cfg_ready; the master holds
// cfg_data stable while cfg_valid is high, and cfg_ready may depend combinationally on loader state.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto ccff_head, gates the chain shift and
// collects the bits coming back on ccff_tail for readback.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  ccff_bitstream_loader_if.slave cfg_if,
  output logic                  ccff_head,
  input  logic                  ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count,
  output logic [WORD_W-1:0]     tail_word,
  output logic [1:0]            state_o
);

  localparam int BL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] tail_q;
  logic [BL_W-1:0]   bits_left_q;
  logic [CNT_W-1:0]  bit_count_q;
  logic              busy_q;
  logic              done_q;

  logic              in_load;
  logic              shift_en;
  logic              ready;
  logic              take_word;
  logic              last_bit;
  logic [31:0]       room;
  logic [BL_W-1:0]   load_bits;

  // room = chain bits not yet shifted and not already sitting in the shift register
  always_comb begin
    in_load   = (state_q == S_LOAD);
    shift_en  = in_load && (bits_left_q != '0);
    room      = 32'(CHAIN_LEN) - 32'(bit_count_q) - 32'(bits_left_q);
    ready     = in_load
                && ((bits_left_q == '0) || ((bits_left_q == BL_W'(1)) && shift_en))
                && (room != 32'd0);
    load_bits = (room >= 32'(WORD_W)) ? BL_W'(WORD_W) : BL_W'(room);
    take_word = cfg_if.cfg_valid && ready;
    last_bit  = shift_en && (bit_count_q == CNT_W'(CHAIN_LEN - 1));
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      tail_q      <= '0;
      bits_left_q <= '0;
      bit_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            bit_count_q <= '0;
            tail_q      <= '0;
            shift_q     <= '0;
            bits_left_q <= '0;
          end
        end
        S_LOAD: begin
          if (shift_en) begin
            shift_q     <= shift_q << 1;
            bits_left_q <= bits_left_q - BL_W'(1);
            bit_count_q <= bit_count_q + CNT_W'(1);
            tail_q      <= {tail_q[WORD_W-2:0], ccff_tail};
          end
          if (take_word) begin
            shift_q     <= cfg_if.cfg_data;
            bits_left_q <= load_bits;
          end
          // The gated prog_clk still fires on the abort edge, so that bit is counted
          // before the loader drops the rest of the word.
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            shift_q     <= '0;
            bits_left_q <= '0;
          end else if (last_bit) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_if.cfg_ready = ready;
  assign ccff_shift_en    = shift_en;
  assign ccff_head        = shift_q[WORD_W-1];
  assign busy             = busy_q;
  assign done             = done_q;
  assign bit_count        = bit_count_q;
  assign tail_word        = tail_q;
  assign state_o          = state_q;

endmodule
